mem_line_responder: RTL and testbench
=====================================

Name: mem_line_responder

Overview:
- Main-memory responder at the far end of the processor's cache-miss/writeback interface. The cache is the initiator; this block answers.
- Accepts one line-granular read or write request at a time, waits a fixed access latency, then returns a one-cycle response.
- Sits beside the processor top level; the processor testbench instantiates it as backing store.

Parameters:
ADDR_W, 32, byte-address width
LINE_W, 128, cache-line width in bits (power of two, >= 32)
DEPTH, 64, number of lines stored (power of two)
LATENCY, 5, cycles from acceptance to response (>= 1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
mem_req_valid  input  1  request present
mem_req_ready  output  1  responder can accept
mem_req_write  input  1  1 = line write, 0 = line read
mem_req_addr  input  ADDR_W  byte address of line
mem_req_wdata  input  LINE_W  write line data
mem_resp_valid  output  1  one-cycle response strobe
mem_resp_rdata  output  LINE_W  read data (write: echo of written line)
mem_busy  output  1  request in flight

Behaviour:
- Reset (async, immediate): state IDLE, counter 0, mem_req_ready=1, mem_resp_valid=0, mem_resp_rdata=0, mem_busy=0. Array contents are zero at time 0 and are NOT cleared by rst.
- Index = mem_req_addr[OFF+IDX-1 : OFF], OFF=log2(LINE_W/8), IDX=log2(DEPTH). Offset bits ignored; upper bits ignored (aliasing allowed, no error).
- FSM IDLE -> WAIT -> RESP -> IDLE.
- IDLE: ready=1. On an edge with valid&&ready: latch write, index, wdata; counter := LATENCY-1; go to WAIT. Without valid, stay.
- WAIT: ready=0, busy=1. Counter decrements each edge; at counter==0 go to RESP. At that same edge, a write commits wdata to the array and a read latches array[index] into mem_resp_rdata.
- RESP: resp_valid=1 for exactly one cycle; busy=1, ready=0; next edge go to IDLE. Write response: rdata = written line.
- Latency: request accepted at edge N; resp_valid high during the cycle following edge N+LATENCY. ready returns high the cycle after resp_valid. Max throughput: one request per LATENCY+2 cycles.
- mem_resp_rdata holds its last value outside RESP.
- Requests while not ready are ignored; the initiator must hold valid. Request inputs are not sampled outside the accept edge.
- rst mid-WAIT: pending write discarded (array unchanged), no response issued.
- rst asserted in the same cycle as RESP: resp_valid drops immediately.
- Read-after-write to the same line: the read returns the new data, because the write committed before ready reasserted.
- Back-to-back requests: a request valid in the IDLE cycle right after RESP is accepted at that edge.

Decomposition:
- constants.v: add `MEM_LATENCY`, `LINE_W`, `MEM_DEPTH` defines and FSM state encodings (`MR_IDLE`, `MR_WAIT`, `MR_RESP`), 2-bit.
- One sub-module, mem_line_array: synchronous write / registered read, DEPTH x LINE_W, single port, zero-initialized. The FSM and counter stay in mem_line_responder.

Test Plan:
- Reset then idle: after rst pulse of 10 time units, mem_req_ready=1, mem_resp_valid=0, mem_resp_rdata=0, mem_busy=0.
- Cold read: read addr 0x40 -> resp_valid exactly 5 cycles after accept edge, rdata=0; ready high the following cycle.
- Write then read: write addr 0x30 data 0xDEADBEEF_01234567_89ABCDEF_CAFEF00D -> response echoes that data; then read 0x3C (same line, offset ignored) -> same 128-bit value.
- Aliasing: write 0x10 = 0x1111..., read 0x410 (DEPTH=64, LINE 16B) -> returns 0x1111...
- Reset mid-write: write 0x20 = 0xFFFF...; assert rst 2 cycles after accept -> no resp_valid; later read 0x20 returns the prior contents (0).
- Backpressure: hold valid with a second request during WAIT -> not accepted until IDLE; accepted on the first IDLE edge after RESP; response 5 cycles later.

Source files
------------

// File: rtl/mem_line_responder_pkg.sv
// rtl/mem_line_responder_pkg.sv - shared defaults and FSM state type for the line responder
package mem_line_responder_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_LINE_W      = 128;
  localparam int DEF_MEM_DEPTH   = 64;
  localparam int DEF_MEM_LATENCY = 5;

  typedef enum logic [1:0] {
    MR_IDLE = 2'd0,
    MR_WAIT = 2'd1,
    MR_RESP = 2'd2
  } mr_state_t;

  // Counter must hold LATENCY-1; a 1-cycle latency still needs one bit.
  function automatic int cnt_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/mem_line_responder_if.sv
// rtl/mem_line_responder_if.sv - cache-miss/writeback request and response bundle
interface mem_line_responder_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_write;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [LINE_W-1:0] mem_resp_rdata;
  logic              mem_busy;

  modport master (
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_busy
  );

  modport slave (
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_busy
  );

endinterface

// File: rtl/mem_line_array.sv
// rtl/mem_line_array.sv - single-port line store, synchronous write, registered read/echo
module mem_line_array #(
  parameter int LINE_W = 128,
  parameter int DEPTH  = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  // Contents start at zero and deliberately survive rst.
  logic [LINE_W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  // Writes echo the new line so the response carries what was stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= we ? wdata : mem[idx];
    end
  end

endmodule

// File: rtl/mem_line_responder.sv
// rtl/mem_line_responder.sv - fixed-latency main-memory responder for line reads/writes
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int DEPTH   = DEF_MEM_DEPTH,
  parameter int LATENCY = DEF_MEM_LATENCY
) (
  input logic                 clk,
  input logic                 rst,
  mem_line_responder_if.slave bus
);

  localparam int OFF   = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(LATENCY);

  mr_state_t         state;
  mr_state_t         state_next;
  logic [CNT_W-1:0]  cnt;
  logic              write_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;

  logic              accept;
  logic              arr_en;
  logic              ready;
  logic              resp_valid;
  logic              busy;
  logic [LINE_W-1:0] arr_rdata;

  // Offset and upper address bits do not select a line; aliasing is intended.
  logic unused_addr;
  assign unused_addr = ^{bus.mem_req_addr[ADDR_W-1:OFF+IDX_W], bus.mem_req_addr[OFF-1:0]};

  assign accept = (state == MR_IDLE) && bus.mem_req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MR_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      MR_IDLE: if (bus.mem_req_valid) state_next = MR_WAIT;
      MR_WAIT: if (cnt == '0)         state_next = MR_RESP;
      MR_RESP:                        state_next = MR_IDLE;
      default:                        state_next = MR_IDLE;
    endcase
  end

  always_comb begin
    ready      = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b0;
    arr_en     = 1'b0;
    case (state)
      MR_IDLE: ready = 1'b1;
      MR_WAIT: begin
        busy   = 1'b1;
        arr_en = (cnt == '0);
      end
      MR_RESP: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      cnt     <= CNT_W'(LATENCY - 1);
      write_q <= bus.mem_req_write;
      idx_q   <= bus.mem_req_addr[OFF +: IDX_W];
      wdata_q <= bus.mem_req_wdata;
    end else if ((state == MR_WAIT) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  mem_line_array #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (arr_en),
    .we    (write_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  assign bus.mem_req_ready  = ready;
  assign bus.mem_resp_valid = resp_valid;
  assign bus.mem_busy       = busy;
  assign bus.mem_resp_rdata = arr_rdata;

endmodule

// File: tb/tb_mem_line_responder.sv
// tb/tb_mem_line_responder.sv - scoreboard bench for the line responder
module tb_mem_line_responder;

  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 128;
  localparam int DEPTH   = 64;
  localparam int LATENCY = 5;

  typedef struct {
    logic [LINE_W-1:0] data;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  bit   after_resp = 1'b0;

  mem_line_responder_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  mem_line_responder #(
    .ADDR_W  (ADDR_W),
    .LINE_W  (LINE_W),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: pop the scoreboard on each response, check data and timing.
  always @(negedge clk) begin
    if (after_resp) begin
      after_resp = 1'b0;
      check("ready_after_resp", 128'(bus.mem_req_ready), 128'd1);
      check("busy_after_resp", 128'(bus.mem_busy), 128'd0);
    end
    if (bus.mem_resp_valid) begin
      after_resp = 1'b1;
      check("busy_in_resp", 128'(bus.mem_busy), 128'd1);
      check("ready_in_resp", 128'(bus.mem_req_ready), 128'd0);
      if (sb.size() == 0) begin
        check("unexpected_resp", 128'd1, 128'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_data", bus.mem_resp_rdata, e.data);
        check("resp_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  task automatic send(input bit wr, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata,
                      input bit expect_resp, input logic [LINE_W-1:0] exp_data, output int acc);
    bit ok;
    exp_t e;
    ok  = 1'b0;
    acc = -1;
    @(negedge clk);
    bus.mem_req_valid = 1'b1;
    bus.mem_req_write = wr;
    bus.mem_req_addr  = addr;
    bus.mem_req_wdata = wdata;
    for (int t = 0; t < 50; t++) begin
      if (bus.mem_req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 128'd0, 128'd1);
      bus.mem_req_valid = 1'b0;
    end else begin
      acc = cyc + 1;
      if (expect_resp) begin
        e.data = exp_data;
        e.cyc  = acc + LATENCY;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.mem_req_valid = 1'b0;
      bus.mem_req_wdata = {4{32'h5A5A_A5A5}};
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", 128'(sb.size()), 128'd0);
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  localparam logic [LINE_W-1:0] PAT_A = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [LINE_W-1:0] PAT_1 = {32{4'h1}};
  localparam logic [LINE_W-1:0] PAT_F = {LINE_W{1'b1}};
  localparam logic [LINE_W-1:0] PAT_B = 128'h0BAD_F00D_1357_9BDF_2468_ACE0_FEED_FACE;

  initial begin
    int acc_a;
    int acc_b;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_write = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_wdata = '0;
    #10 rst = 1'b0;

    @(negedge clk);
    check("rst_ready", 128'(bus.mem_req_ready), 128'd1);
    check("rst_resp_valid", 128'(bus.mem_resp_valid), 128'd0);
    check("rst_rdata", bus.mem_resp_rdata, 128'd0);
    check("rst_busy", 128'(bus.mem_busy), 128'd0);

    send(1'b0, 32'h40, '0, 1'b1, '0, acc_a);
    @(negedge clk);
    check("busy_in_wait", 128'(bus.mem_busy), 128'd1);
    check("ready_in_wait", 128'(bus.mem_req_ready), 128'd0);
    drain();

    send(1'b1, 32'h30, PAT_A, 1'b1, PAT_A, acc_a);
    drain();
    check("rdata_hold", bus.mem_resp_rdata, PAT_A);
    send(1'b0, 32'h3C, '0, 1'b1, PAT_A, acc_a);
    drain();

    send(1'b1, 32'h10, PAT_1, 1'b1, PAT_1, acc_a);
    drain();
    send(1'b0, 32'h410, '0, 1'b1, PAT_1, acc_a);
    drain();

    // Reset two cycles into a write: no response, array untouched.
    send(1'b1, 32'h20, PAT_F, 1'b0, '0, acc_a);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", 128'(bus.mem_req_ready), 128'd1);
    check("midrst_busy", 128'(bus.mem_busy), 128'd0);
    check("midrst_rdata", bus.mem_resp_rdata, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < LATENCY + 3; t++) @(negedge clk);
    send(1'b0, 32'h20, '0, 1'b1, '0, acc_a);
    drain();

    // Backpressure: second request held through WAIT/RESP, taken on first IDLE edge.
    send(1'b0, 32'h30, '0, 1'b1, PAT_A, acc_a);
    send(1'b1, 32'h50, PAT_B, 1'b1, PAT_B, acc_b);
    check("backpressure_accept", 128'(acc_b), 128'(acc_a + LATENCY + 2));
    send(1'b0, 32'h5F, '0, 1'b1, PAT_B, acc_a);
    check("back_to_back_accept", 128'(acc_a), 128'(acc_b + LATENCY + 2));
    drain();

    check("sb_empty", 128'(sb.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
